// File: rtl/load_store_unit.sv
// Single-issue load/store unit: IDLE -> REQ -> (WB) -> DONE handshake with a simple memory port.
// Optional REQ watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned IMM_W   = 21,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [2:0]            opcode,
   input  logic [DATA_W-1:0]     xs,
   input  logic [DATA_W-1:0]     xd,
   input  logic [IMM_W-1:0]      imm,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [DATA_W-1:0]     y,
   output logic [1:0]            write_which,
   output logic [DATA_W-1:0]     o_port,
   output logic                  o_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;
   typedef enum logic [2:0] {
      OP_SDW, OP_SDH, OP_SDB, OP_LDW, OP_LDH, OP_LDB, OP_OUT, OP_RSV
   } op_t;

   state_t              state_q, state_d;
   op_t                 op_in, op_q;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   addr_q, ea_n;
   logic [OFF_W-1:0]    off_n, off_q;
   logic [NB-1:0]       be_q, be_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n, y_q, y_n, o_port_q, rd_lane;
   logic                st_in, ld_in, misalign, st_q, ld_q, timeout_hit;

   // Address, lanes and alignment are resolved in IDLE so a bad access never reaches REQ
   always_comb begin
      op_in = op_t'(opcode);
      st_in = op_in inside {OP_SDW, OP_SDH, OP_SDB};
      ld_in = op_in inside {OP_LDW, OP_LDH, OP_LDB};
      ea_n  = (st_in ? ADDR_W'(xd) : ADDR_W'(xs)) + ADDR_W'($signed(imm));
      off_n = OFF_W'(ea_n % ADDR_W'(NB));
      misalign = ((op_in == OP_SDH || op_in == OP_LDH) && off_n[0]) ||
                 ((op_in == OP_SDW || op_in == OP_LDW) && off_n != '0);
      be_n    = '1;
      wdata_n = xs;
      if (op_in == OP_SDB || op_in == OP_LDB) begin
         be_n    = NB'(1) << off_n;
         wdata_n = {NB{xs[7:0]}};
      end else if (op_in == OP_SDH || op_in == OP_LDH) begin
         be_n    = NB'(3) << off_n;
         wdata_n = {(NB/2){xs[15:0]}};
      end
   end

   assign st_q  = op_q inside {OP_SDW, OP_SDH, OP_SDB};
   assign ld_q  = op_q inside {OP_LDW, OP_LDH, OP_LDB};
   assign off_q = OFF_W'(addr_q % ADDR_W'(NB));

   always_comb begin
      rd_lane = mem_rdata >> {off_q, 3'b000};
      case (op_q)
         OP_LDB:  y_n = DATA_W'($signed(rd_lane[7:0]));
         OP_LDH:  y_n = DATA_W'($signed(rd_lane[15:0]));
         default: y_n = mem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset)
         cnt_q <= '0;
      else if (state_q == REQ && state_d == REQ)
         cnt_q <= cnt_q + 1'b1;
      else
         cnt_q <= '0;
   end

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (en) begin
               if (op_in == OP_RSV || misalign) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (op_q == OP_OUT)
               state_d = DONE;
            else if (mem_ack)
               state_d = ld_q ? WB : DONE;
            else if (timeout_hit) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         WB:      state_d = DONE;
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         op_q     <= OP_SDW;
         err_q    <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         y_q      <= '0;
         o_port_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (state_q == IDLE && en) begin
            op_q    <= op_in;
            addr_q  <= ea_n;
            be_q    <= be_n;
            wdata_q <= wdata_n;
            if (op_in == OP_OUT)
               o_port_q <= xs;
         end
         if (state_q == REQ && mem_ack && ld_q)
            y_q <= y_n;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign err         = err_q;
   assign mem_req     = (state_q == REQ) && (st_q || ld_q);
   assign mem_we      = (state_q == REQ) && st_q;
   assign mem_be      = mem_req ? be_q : '0;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign o_valid     = (state_q == REQ) && (op_q == OP_OUT);
   assign o_port      = o_port_q;
   assign y           = y_q;
   assign write_which = (state_q == WB) ? 2'b01 :
                        ((state_q == REQ && st_q) ? 2'b10 : 2'b00);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; timeout scenario switches on LSU_TIMEOUT_EN.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic [2:0]  opcode = 3'b000;
   logic [31:0] xs = '0, xd = '0;
   logic [20:0] imm = '0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, y, o_port;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [1:0]  write_which;
   logic        o_valid, busy, done, err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   load_store_unit #(.DATA_W(32), .ADDR_W(32), .IMM_W(21), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .en(en), .opcode(opcode), .xs(xs), .xd(xd), .imm(imm),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .y(y),
      .write_which(write_which), .o_port(o_port), .o_valid(o_valid),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation: en is high for exactly one sampled edge
   task automatic start(input logic [2:0] op, input logic [31:0] s, input logic [31:0] d,
                        input logic [20:0] im);
      opcode = op; xs = s; xd = d; imm = im; en = 1'b1;
      step();
      en = 1'b0;
   endtask

   initial begin
      int unsigned n;

      // reset state
      step(); step();
      check("rst_req", mem_req, 0);     check("rst_we", mem_we, 0);
      check("rst_be", mem_be, 0);       check("rst_ww", write_which, 0);
      check("rst_ov", o_valid, 0);      check("rst_busy", busy, 0);
      check("rst_done", done, 0);       check("rst_err", err, 0);
      check("rst_addr", mem_addr, 0);   check("rst_wdata", mem_wdata, 0);
      check("rst_y", y, 0);             check("rst_oport", o_port, 0);
      reset = 1'b1;
      step();

      // SDW with negative offset, ack in first REQ cycle
      start(3'b000, 32'hDEADBEEF, 32'h100, 21'h1FFFFC);
      check("sdw_req", mem_req, 1);     check("sdw_we", mem_we, 1);
      check("sdw_addr", mem_addr, 32'hFC);
      check("sdw_be", mem_be, 4'b1111);
      check("sdw_wdata", mem_wdata, 32'hDEADBEEF);
      check("sdw_ww", write_which, 2'b10);
      check("sdw_busy", busy, 1);       check("sdw_done_early", done, 0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      // third cycle counting the en cycle as the first
      check("sdw_done", done, 1);       check("sdw_err", err, 0);
      check("sdw_req_off", mem_req, 0); check("sdw_ww_off", write_which, 0);
      step();
      check("sdw_idle", busy, 0);       check("sdw_done_off", done, 0);

      // SDB lane 3 and SDH upper half: replication and lane enables
      start(3'b010, 32'h000000A5, 32'h103, 21'h0);
      check("sdb_addr", mem_addr, 32'h103);
      check("sdb_be", mem_be, 4'b1000);
      check("sdb_wdata", mem_wdata, 32'hA5A5A5A5);
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      check("sdb_done", done, 1);
      step();
      start(3'b001, 32'h00001234, 32'h100, 21'h2);
      check("sdh_be", mem_be, 4'b1100);
      check("sdh_wdata", mem_wdata, 32'h12341234);
      mem_ack = 1'b1; step(); mem_ack = 1'b0;
      check("sdh_done", done, 1);
      step();

      // LDB with ack after 5 REQ cycles, negative byte
      start(3'b101, 32'h200, 32'h0, 21'h3);
      for (int i = 0; i < 4; i++) begin
         check("ldb_wait_req", mem_req, 1);
         check("ldb_wait_addr", mem_addr, 32'h203);
         check("ldb_wait_we", mem_we, 0);
         step();
      end
      mem_ack = 1'b1; mem_rdata = 32'h80FFFFFF;
      step();
      mem_ack = 1'b0; mem_rdata = '0;
      check("ldb_y", y, 32'hFFFFFF80);
      check("ldb_ww", write_which, 2'b01);
      check("ldb_wb_req", mem_req, 0);
      step();
      check("ldb_ww_off", write_which, 0);
      check("ldb_done", done, 1);
      check("ldb_y_hold", y, 32'hFFFFFF80);
      step();

      // LDH positive upper half; LDW negative offset; load latency of 4 cycles
      start(3'b100, 32'h300, 32'h0, 21'h2);
      mem_ack = 1'b1; mem_rdata = 32'h7FFF1234; step(); mem_ack = 1'b0;
      check("ldh_y", y, 32'h00007FFF);
      step();
      check("ldh_done", done, 1);
      step();
      start(3'b011, 32'h400, 32'h0, 21'h1FFFF8);
      check("ldw_addr", mem_addr, 32'h3F8);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; step(); mem_ack = 1'b0;
      check("ldw_y", y, 32'hCAFEF00D);
      step();
      check("ldw_done", done, 1);
      step();

      // misaligned LDH, misaligned SDW, reserved opcode: straight to DONE with err
      start(3'b100, 32'h200, 32'h0, 21'h1);
      check("mis_ldh_req", mem_req, 0);
      check("mis_ldh_done", done, 1);   check("mis_ldh_err", err, 1);
      step();
      check("mis_ldh_err_clr", err, 0); check("mis_ldh_idle", busy, 0);
      start(3'b000, 32'h0, 32'h102, 21'h0);
      check("mis_sdw_req", mem_req, 0); check("mis_sdw_err", err, 1);
      step();
      start(3'b111, 32'h0, 32'h0, 21'h0);
      check("rsv_req", mem_req, 0);     check("rsv_done", done, 1);
      check("rsv_err", err, 1);
      step();

`ifdef LSU_TIMEOUT_EN
      // no ack: mem_req must drop after exactly 16 REQ cycles
      start(3'b011, 32'h500, 32'h0, 21'h0);
      n = 0;
      while (mem_req && n < 40) begin
         check("to_ww", write_which, 0);
         n++;
         step();
      end
      check("to_cycles", n, 16);
      check("to_done", done, 1);        check("to_err", err, 1);
      check("to_ww_done", write_which, 0);
      check("to_y_hold", y, 32'hCAFEF00D);
      step();
`else
      // without the watchdog, REQ waits as long as it takes
      start(3'b011, 32'h500, 32'h0, 21'h0);
      n = 0;
      while (mem_req && n < 30) begin
         n++;
         step();
      end
      check("nto_cycles", n, 30);
      check("nto_err", err, 0);
      mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE; step(); mem_ack = 1'b0;
      check("nto_y", y, 32'h0BADCAFE);
      step();
      check("nto_done", done, 1);       check("nto_err_done", err, 0);
      step();
`endif

      // reset during REQ of LDW
      start(3'b011, 32'h600, 32'h0, 21'h0);
      check("mrst_req_pre", mem_req, 1);
      reset = 1'b0;
      step();
      check("mrst_req", mem_req, 0);    check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);      check("mrst_err", err, 0);
      check("mrst_ww", write_which, 0); check("mrst_be", mem_be, 0);
      check("mrst_addr", mem_addr, 0);  check("mrst_y", y, 0);
      reset = 1'b1;
      step();
      check("mrst_no_done", done, 0);   check("mrst_idle", busy, 0);

      // OUT, with en held (and a different op presented) while busy
      opcode = 3'b110; xs = 32'h12345678; en = 1'b1;
      step();
      opcode = 3'b011; xs = 32'h999;
      check("out_ov", o_valid, 1);      check("out_port", o_port, 32'h12345678);
      check("out_req", mem_req, 0);     check("out_busy", busy, 1);
      step();
      check("out_ov_off", o_valid, 0);  check("out_done", done, 1);
      check("out_req_done", mem_req, 0);
      en = 1'b0;
      step();
      check("out_idle", busy, 0);       check("out_port_hold", o_port, 32'h12345678);
      check("out_ignored_req", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- DATA_W, 32, data/word width in bits; multiple of 16.
- ADDR_W, 32, byte-address width.
- IMM_W, 21, immediate width; sign-extended to ADDR_W.
- TIMEOUT, 16, max cycles waiting for mem_ack; minimum 2.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, sole clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-low.
- en, in, 1, start; sampled in IDLE only.
- opcode, in, 3, 000 SDW, 001 SDH, 010 SDB, 011 LDW, 100 LDH, 101 LDB, 110 OUT, 111 reserved.
- xs, in, DATA_W, store data / load base.
- xd, in, DATA_W, store base.
- imm, in, IMM_W, signed offset.
- mem_req / mem_we, out, 1, memory request / write strobe.
- mem_addr, out, ADDR_W, byte address.
- mem_be, out, DATA_W/8, byte enables.
- mem_wdata, out, DATA_W, write data.
- mem_ack, in, 1, memory accepted (store) or rdata valid (load).
- mem_rdata, in, DATA_W, read data.
- y, out, DATA_W, load result.
- write_which, out, 2, 01 regfile, 10 memory, 00 nothing.
- o_port, out, DATA_W; o_valid, out, 1: OUT result port.
- busy / done / err, out, 1: status.

Function
REQ-003 FSM states SHALL be IDLE, REQ, WB, DONE; busy=1 in every state except IDLE.
REQ-004 IDLE with en=1 SHALL latch opcode, xs, xd, imm and go to REQ next cycle; en in any other state SHALL be ignored.
REQ-005 Effective address SHALL be xd+sext(imm) for stores and xs+sext(imm) for loads, truncated to ADDR_W, wrapping modulo 2^ADDR_W.
REQ-006 Misalignment (half at odd address; word with addr mod DATA_W/8 != 0) SHALL skip REQ, go directly to DONE with err=1, and issue no memory access.
REQ-007 In REQ, mem_req SHALL stay 1 with stable mem_addr/mem_be/mem_wdata/mem_we until the cycle mem_ack=1; mem_we=1 only for stores.
REQ-008 Stores SHALL replicate byte/half data across lanes, set only the addressed lanes in mem_be (little-endian), set write_which=10 during REQ, and go REQ->DONE on mem_ack.
REQ-009 Loads SHALL capture mem_rdata on mem_ack, select the addressed lane, sign-extend LDB/LDH to DATA_W, and go to WB.
REQ-010 WB SHALL last exactly one cycle with y valid and write_which=01, then go to DONE.
REQ-011 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-012 Latency with mem_ack in the first REQ cycle SHALL be: store, done 3 cycles after the en cycle; load, 4 cycles.
REQ-013 OUT SHALL drive o_port=xs with o_valid=1 for one cycle (no memory access), then go to DONE.
REQ-014 Reserved opcode SHALL go to DONE with err=1.
REQ-015 write_which SHALL be 00 whenever not in a state given above; y and o_port SHALL hold their last value.

Reset
REQ-016 reset=0 at a clock edge SHALL force IDLE from any state, including mid-REQ, and drop mem_req the next cycle.
REQ-017 On reset, mem_req, mem_we, mem_be, write_which, o_valid, busy, done and err SHALL be 0; mem_addr, mem_wdata, y and o_port SHALL be 0.

Configuration
REQ-018 With macro LSU_TIMEOUT_EN defined, a counter SHALL run in REQ; if mem_ack is not seen within TIMEOUT cycles, the FSM SHALL drop mem_req and go to DONE with err=1, with no writeback.
REQ-019 Without LSU_TIMEOUT_EN, REQ SHALL wait indefinitely and err SHALL arise only from misalignment or a reserved opcode.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- SDW, xd=0x100, imm=0x1FFFFC (-4), xs=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0xFC, mem_be=1111, mem_we=1, done 3 cycles after en.
- LDB, xs=0x200, imm=3, rdata=0x80FFFFFF, ack after 5 cycles -> y=0xFFFFFF80, write_which=01 for one cycle.
- LDH, addr=0x201 -> err=1, done=1, mem_req never asserted.
- LSU_TIMEOUT_EN, TIMEOUT=16, no ack -> mem_req drops after 16 REQ cycles, err=1, write_which stays 00.
- reset=0 during REQ of LDW -> IDLE next cycle, all outputs 0, no done pulse.
- OUT, xs=0x12345678 -> o_port=0x12345678, o_valid one cycle, en asserted while busy ignored.
